// File: rtl/agg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : agg_pkg
// Description : Shared types, default geometry and width helpers for the
//               aggregation transpose buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package agg_pkg;

    localparam int AGG_WORD_WIDTH     = 16;
    localparam int AGG_STENCIL_HEIGHT = 2;
    localparam int AGG_MEM_WIDTH      = 4;

    typedef logic [AGG_WORD_WIDTH-1:0] pixel_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_e;

    // Column counter must reach MEM_WIDTH itself, hence the extra bit.
    function automatic int col_idx_w(input int mem_width);
        return $clog2(mem_width) + 1;
    endfunction

    function automatic int row_idx_w(input int stencil_height);
        return (stencil_height > 1) ? $clog2(stencil_height) : 1;
    endfunction

endpackage : agg_pkg
`default_nettype wire

// File: rtl/agg_bank.sv
`default_nettype none
// ============================================================================
// Module      : agg_bank
// Description : One STENCIL_HEIGHT x MEM_WIDTH pixel bank with a column write
//               port, a masked row read port and a lane-valid mask register.
// Revision    : 1.0 - initial release
// ============================================================================
module agg_bank
    import agg_pkg::*;
#(
    parameter int WORD_WIDTH     = AGG_WORD_WIDTH,
    parameter int STENCIL_HEIGHT = AGG_STENCIL_HEIGHT,
    parameter int MEM_WIDTH      = AGG_MEM_WIDTH,
    parameter int COL_W          = col_idx_w(MEM_WIDTH),
    parameter int ROW_W          = row_idx_w(STENCIL_HEIGHT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_wr_en,
    input  logic [COL_W-1:0]                i_wr_col,
    input  logic [STENCIL_HEIGHT*WORD_WIDTH-1:0] i_col_pixels,
    input  logic                            i_mask_we,
    input  logic [MEM_WIDTH-1:0]            i_mask,
    input  logic [ROW_W-1:0]                i_rd_row,
    output logic [MEM_WIDTH*WORD_WIDTH-1:0] o_row_data,
    output logic [MEM_WIDTH-1:0]            o_mask
);

    logic [WORD_WIDTH-1:0] r_cells [STENCIL_HEIGHT][MEM_WIDTH];
    logic [MEM_WIDTH-1:0]  r_mask;

    // Pixel storage is deliberately left unreset; the mask gates every read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int c = 0; c < MEM_WIDTH; c++) begin
                for (int r = 0; r < STENCIL_HEIGHT; r++) begin
                    if (i_wr_col == COL_W'(c)) begin
                        r_cells[r][c] <= i_col_pixels[r*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (i_mask_we) begin
            r_mask <= i_mask;
        end
    end

    always_comb begin
        o_row_data = '0;
        for (int i = 0; i < MEM_WIDTH; i++) begin
            if (r_mask[i]) begin
                o_row_data[i*WORD_WIDTH +: WORD_WIDTH] = r_cells[i_rd_row][i];
            end
        end
    end

    assign o_mask = r_mask;

endmodule : agg_bank
`default_nettype wire

// File: rtl/agg_transpose_buffer.sv
`default_nettype none
// ============================================================================
// Module      : agg_transpose_buffer
// Description : Accepts stencil columns into ping-pong banks and drains them
//               as masked MEM_WIDTH-pixel row words toward a memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
module agg_transpose_buffer
    import agg_pkg::*;
#(
    parameter int WORD_WIDTH     = AGG_WORD_WIDTH,
    parameter int STENCIL_HEIGHT = AGG_STENCIL_HEIGHT,
    parameter int MEM_WIDTH      = AGG_MEM_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [STENCIL_HEIGHT*WORD_WIDTH-1:0] col_pixels,
    input  logic                                 col_valid,
    output logic                                 col_ready,
    input  logic                                 flush,
    output logic [MEM_WIDTH*WORD_WIDTH-1:0]      mem_data,
    output logic [MEM_WIDTH-1:0]                 valid_output,
    output logic                                 mem_valid,
    input  logic                                 mem_ready
);

    localparam int COL_W = col_idx_w(MEM_WIDTH);
    localparam int ROW_W = row_idx_w(STENCIL_HEIGHT);

    logic [1:0]       r_bank_full;
    bank_sel_e        r_fill_sel;
    bank_sel_e        r_drain_sel;
    logic [COL_W-1:0] r_col_index;
    logic [ROW_W-1:0] r_row_index;

    logic                            w_fill_b;
    logic                            w_drain_b;
    logic                            w_accept;
    logic [COL_W-1:0]                w_count;
    logic                            w_close;
    logic                            w_release;
    logic [MEM_WIDTH-1:0]            w_close_mask;
    logic [MEM_WIDTH*WORD_WIDTH-1:0] w_row_data [2];
    logic [MEM_WIDTH-1:0]            w_bank_mask [2];

    assign w_fill_b  = (r_fill_sel == BANK1);
    assign w_drain_b = (r_drain_sel == BANK1);

    assign col_ready = !r_bank_full[w_fill_b];
    assign mem_valid = r_bank_full[w_drain_b];
    assign w_accept  = col_valid && col_ready;
    assign w_count   = r_col_index + COL_W'(w_accept);

    // A flush that also accepts the last column is just a normal full close.
    assign w_close = (w_accept && (r_col_index == COL_W'(MEM_WIDTH - 1)))
                  || (flush && col_ready && (w_count != '0));
    assign w_release = mem_valid && mem_ready
                    && (r_row_index == ROW_W'(STENCIL_HEIGHT - 1));

    always_comb begin
        w_close_mask = '0;
        for (int i = 0; i < MEM_WIDTH; i++) begin
            w_close_mask[i] = (COL_W'(i) < w_count);
        end
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            agg_bank #(
                .WORD_WIDTH     (WORD_WIDTH),
                .STENCIL_HEIGHT (STENCIL_HEIGHT),
                .MEM_WIDTH      (MEM_WIDTH),
                .COL_W          (COL_W),
                .ROW_W          (ROW_W)
            ) u_bank (
                .clk          (clk),
                .rst          (rst),
                .i_wr_en      (w_accept && (w_fill_b == 1'(b))),
                .i_wr_col     (r_col_index),
                .i_col_pixels (col_pixels),
                .i_mask_we    (w_close && (w_fill_b == 1'(b))),
                .i_mask       (w_close_mask),
                .i_rd_row     (r_row_index),
                .o_row_data   (w_row_data[b]),
                .o_mask       (w_bank_mask[b])
            );
        end
    endgenerate

    assign mem_data     = mem_valid ? w_row_data[w_drain_b]  : '0;
    assign valid_output = mem_valid ? w_bank_mask[w_drain_b] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_full <= 2'b00;
            r_fill_sel  <= BANK0;
            r_drain_sel <= BANK0;
            r_col_index <= '0;
            r_row_index <= '0;
        end else begin
            // Close and release always target different banks, so both may land together.
            if (w_close) begin
                r_bank_full[w_fill_b] <= 1'b1;
                r_fill_sel            <= (r_fill_sel == BANK0) ? BANK1 : BANK0;
                r_col_index           <= '0;
            end else if (w_accept) begin
                r_col_index <= r_col_index + 1'b1;
            end

            if (w_release) begin
                r_bank_full[w_drain_b] <= 1'b0;
                r_drain_sel            <= (r_drain_sel == BANK0) ? BANK1 : BANK0;
                r_row_index            <= '0;
            end else if (mem_valid && mem_ready) begin
                r_row_index <= r_row_index + 1'b1;
            end
        end
    end

endmodule : agg_transpose_buffer
`default_nettype wire

// File: tb/tb_agg_transpose_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_agg_transpose_buffer
// Description : Scoreboard bench for agg_transpose_buffer with a column-list
//               reference model, directed scenarios and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agg_transpose_buffer;

    localparam int WW = 16;
    localparam int SH = 2;
    localparam int MW = 4;

    typedef struct {
        logic [MW*WW-1:0] data;
        logic [MW-1:0]    mask;
        int               row;
        int               avail;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [SH*WW-1:0] col_pixels;
    logic             col_valid;
    logic             col_ready;
    logic             flush;
    logic [MW*WW-1:0] mem_data;
    logic [MW-1:0]    valid_output;
    logic             mem_valid;
    logic             mem_ready;

    agg_transpose_buffer #(
        .WORD_WIDTH     (WW),
        .STENCIL_HEIGHT (SH),
        .MEM_WIDTH      (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col_pixels   (col_pixels),
        .col_valid    (col_valid),
        .col_ready    (col_ready),
        .flush        (flush),
        .mem_data     (mem_data),
        .valid_output (valid_output),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int closed = 0;
    exp_t             q[$];
    logic [SH*WW-1:0] cols[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a closed bank of n columns yields SH words; lane i of word r is column i's pixel r.
    task automatic close_bank();
        int n;
        n = cols.size();
        for (int r = 0; r < SH; r++) begin
            exp_t e;
            e.data  = '0;
            e.mask  = '0;
            e.row   = r;
            e.avail = cyc + 1;
            for (int i = 0; i < n; i++) begin
                e.data[i*WW +: WW] = cols[i][r*WW +: WW];
                e.mask[i]          = 1'b1;
            end
            q.push_back(e);
        end
        closed++;
        cols.delete();
    endtask

    task automatic step(input logic v, input logic [SH*WW-1:0] px, input logic fl, input logic rdy);
        logic exp_ready;
        @(posedge clk);
        #1;
        col_valid  = v;
        col_pixels = px;
        flush      = fl;
        mem_ready  = rdy;
        exp_ready  = (closed < 2);
        check("col_ready", 64'(col_ready), 64'(exp_ready));
        if (v && exp_ready) cols.push_back(px);
        if (cols.size() == MW) close_bank();
        else if (fl && exp_ready && cols.size() > 0) close_bank();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        col_valid = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        q.delete();
        cols.delete();
        closed = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_col_ready", 64'(col_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_data", 64'(mem_data), 64'd0);
        check("rst_valid_output", 64'(valid_output), 64'd0);
    endtask

    function automatic logic [SH*WW-1:0] colpx(input int a, input int b);
        logic [SH*WW-1:0] p;
        p = '0;
        p[0 +: WW]  = WW'(a);
        p[WW +: WW] = WW'(b);
        return p;
    endfunction

    // Monitor: compares whatever the DUT presents against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            logic ev;
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            check("mem_valid", 64'(mem_valid), 64'(ev));
            if (ev) begin
                check("mem_data", 64'(mem_data), 64'(q[0].data));
                check("valid_output", 64'(valid_output), 64'(q[0].mask));
                if (mem_ready) begin
                    if (q[0].row == SH - 1) closed--;
                    void'(q.pop_front());
                end
            end else begin
                check("idle_valid_output", 64'(valid_output), 64'd0);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        col_valid  = 1'b0;
        col_pixels = '0;
        flush      = 1'b0;
        mem_ready  = 1'b0;
        do_reset();

        // Full bank stream, immediate drain.
        for (int i = 0; i < 4; i++) step(1'b1, colpx(16'h10 + i, 16'h20 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: both banks fill, ninth column held.
        for (int i = 0; i < 9; i++) step(1'b1, colpx(16'h100 + i, 16'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, colpx(16'h108, 16'h208), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Partial bank via flush, then a stream into the other bank.
        for (int i = 0; i < 3; i++) step(1'b1, colpx(16'hA0 + i, 16'hB0 + i), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, colpx(16'hC0 + i, 16'hD0 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Flush coinciding with the second accept.
        step(1'b1, colpx(16'h31, 16'h41), 1'b0, 1'b1);
        step(1'b1, colpx(16'h32, 16'h42), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Flush with an empty fill bank does nothing.
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset after the first drain handshake.
        for (int i = 0; i < 4; i++) step(1'b1, colpx(16'h50 + i, 16'h60 + i), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, colpx(16'h70 + i, 16'h80 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_agg_transpose_buffer
`default_nettype wire
